// File: rtl/rtc_disp_scan.sv
// Six-digit 7-segment scan driver: per-frame snapshot of the RTC digit patterns,
// time-multiplexed onto a shared segment bus with one-hot digit enables.
module rtc_disp_scan #(
  parameter int unsigned DIV            = 50000,
  parameter int unsigned BLANK_CYC      = 500,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       en,
  input  logic [6:0] hrm,
  input  logic [6:0] hrl,
  input  logic [6:0] min_m,
  input  logic [6:0] min_l,
  input  logic [6:0] sec_m,
  input  logic [6:0] sec_l,
  output logic [6:0] seg,
  output logic [5:0] an,
  output logic       frame_start
);

  localparam int unsigned PW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PcntLast = PW'(DIV - 1);
  localparam logic [PW-1:0] BlankEnd = PW'(BLANK_CYC);
  localparam logic [6:0]    SegOff   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [5:0]    AnOff    = AN_ACTIVE_LOW ? 6'h3F : 6'h00;

  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic [2:0]      dig_q, dig_d;
  logic [5:0][6:0] shadow_q, shadow_d;
  logic [6:0]      seg_q, seg_d;
  logic [5:0]      an_q, an_d;
  logic            fs_q, fs_d;
  logic [6:0]      cur_pat;
  logic [5:0][6:0] inputs;

  assign inputs = {sec_l, sec_m, min_l, min_m, hrl, hrm};

  always_comb begin
    cur_pat = 7'h00;
    case (dig_q)
      3'd0:    cur_pat = shadow_q[0];
      3'd1:    cur_pat = shadow_q[1];
      3'd2:    cur_pat = shadow_q[2];
      3'd3:    cur_pat = shadow_q[3];
      3'd4:    cur_pat = shadow_q[4];
      3'd5:    cur_pat = shadow_q[5];
      default: cur_pat = 7'h00;
    endcase
  end

  always_comb begin
    pcnt_d   = pcnt_q;
    dig_d    = dig_q;
    shadow_d = shadow_q;
    seg_d    = SegOff;
    an_d     = AnOff;
    fs_d     = 1'b0;
    if (!en) begin
      pcnt_d   = '0;
      dig_d    = 3'd0;
      shadow_d = inputs;
    end else begin
      fs_d = (dig_q == 3'd0) && (pcnt_q == '0);
      // Outputs reflect the state before this edge; the first BLANK_CYC counts stay dark.
      if (pcnt_q >= BlankEnd) begin
        an_d  = (6'b000001 << dig_q) ^ AnOff;
        seg_d = cur_pat ^ SegOff;
      end
      if (pcnt_q == PcntLast) begin
        pcnt_d = '0;
        if (dig_q == 3'd5) begin
          dig_d    = 3'd0;
          shadow_d = inputs;
        end else begin
          dig_d = dig_q + 3'd1;
        end
      end else begin
        pcnt_d = pcnt_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pcnt_q   <= '0;
      dig_q    <= 3'd0;
      shadow_q <= '0;
      seg_q    <= SegOff;
      an_q     <= AnOff;
      fs_q     <= 1'b0;
    end else begin
      pcnt_q   <= pcnt_d;
      dig_q    <= dig_d;
      shadow_q <= shadow_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      fs_q     <= fs_d;
    end
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_rtc_disp_scan.sv
// Bench for rtc_disp_scan: an active-low and an active-high instance scanned side by side
// against a per-cycle scoreboard built from hand-encoded digit patterns.
module tb_rtc_disp_scan;

  localparam logic [6:0] P1 = 7'b0110000;
  localparam logic [6:0] P2 = 7'b1101101;
  localparam logic [6:0] P3 = 7'b1111001;
  localparam logic [6:0] P4 = 7'b0110011;
  localparam logic [6:0] P5 = 7'b1011011;
  localparam logic [6:0] P6 = 7'b1011111;
  localparam logic [6:0] P7 = 7'b1110000;
  localparam logic [6:0] P8 = 7'b1111111;
  localparam logic [6:0] P9 = 7'b1111011;

  // Index 0 = hrm ... index 5 = sec_l
  localparam logic [5:0][6:0] T55 = {P5, P5, P4, P3, P2, P1};
  localparam logic [5:0][6:0] T56 = {P6, P5, P4, P3, P2, P1};
  localparam logic [5:0][6:0] T57 = {P7, P5, P4, P3, P2, P1};
  localparam logic [5:0][6:0] T58 = {P8, P5, P4, P3, P2, P1};
  localparam logic [5:0][6:0] T59 = {P9, P5, P4, P3, P2, P1};

  typedef struct {
    logic [5:0] an;
    logic [6:0] seg;
    logic       fs;
  } exp_t;

  typedef struct {
    logic [5:0][6:0] pats;
    logic            dark;
    int              chg_idx;
    logic [6:0]      chg_val;
  } frame_t;

  logic       clk;
  logic       rstn;
  logic       en;
  logic [6:0] hrm, hrl, min_m, min_l, sec_m, sec_l;
  logic [6:0] seg_lo, seg_hi;
  logic [5:0] an_lo, an_hi;
  logic       fs_lo, fs_hi;

  int tests = 0;
  int fails = 0;
  exp_t exp_q[$];
  frame_t frames[7];

  rtc_disp_scan #(
    .DIV(4), .BLANK_CYC(1), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut_lo (
    .clk(clk), .rstn(rstn), .en(en),
    .hrm(hrm), .hrl(hrl), .min_m(min_m), .min_l(min_l), .sec_m(sec_m), .sec_l(sec_l),
    .seg(seg_lo), .an(an_lo), .frame_start(fs_lo)
  );

  rtc_disp_scan #(
    .DIV(4), .BLANK_CYC(1), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
  ) dut_hi (
    .clk(clk), .rstn(rstn), .en(en),
    .hrm(hrm), .hrl(hrl), .min_m(min_m), .min_l(min_l), .sec_m(sec_m), .sec_l(sec_l),
    .seg(seg_hi), .an(an_hi), .frame_start(fs_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_dark();
    exp_t e;
    e.an  = 6'h3F;
    e.seg = 7'h7F;
    e.fs  = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic check(input string tag);
    exp_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = exp_q.pop_front();
    if ({an_lo, seg_lo, fs_lo} !== {e.an, e.seg, e.fs}) begin
      fails++;
      $display("FAIL %s lo: got an=%b seg=%b fs=%b, want an=%b seg=%b fs=%b",
               tag, an_lo, seg_lo, fs_lo, e.an, e.seg, e.fs);
    end
    tests++;
    if ({an_hi, seg_hi, fs_hi} !== {~e.an, ~e.seg, e.fs}) begin
      fails++;
      $display("FAIL %s hi: got an=%b seg=%b fs=%b, want an=%b seg=%b fs=%b",
               tag, an_hi, seg_hi, fs_hi, ~e.an, ~e.seg, e.fs);
    end
  endtask

  // Expected (active-low) view of cycle e of a frame with DIV=4, BLANK_CYC=1.
  task automatic run_cycles(input logic [5:0][6:0] pats, input logic dark, input int n,
                            input int chg_idx, input logic [6:0] chg_val, input string tag);
    for (int e = 0; e < n; e++) begin
      exp_t x;
      int d;
      logic blank;
      d       = e / 4;
      blank   = (e % 4) == 0;
      x.an    = blank ? 6'h3F : ~(6'b000001 << d);
      x.seg   = (blank || dark) ? 7'h7F : ~pats[d];
      x.fs    = (e == 0);
      exp_q.push_back(x);
      @(negedge clk);
      check($sformatf("%s c%0d", tag, e));
      if (e == chg_idx) sec_l = chg_val;
    end
  endtask

  initial begin
    frames[0] = '{T56, 1'b1, -1, 7'h00};
    frames[1] = '{T56, 1'b0, -1, 7'h00};
    frames[2] = '{T56, 1'b0,  9, P7};
    frames[3] = '{T57, 1'b0, 22, P8};
    frames[4] = '{T58, 1'b0, 23, P9};
    frames[5] = '{T58, 1'b0, -1, 7'h00};
    frames[6] = '{T59, 1'b0, -1, 7'h00};

    rstn  = 1'b1;
    en    = 1'b1;
    hrm   = P1;
    hrl   = P2;
    min_m = P3;
    min_l = P4;
    sec_m = P5;
    sec_l = P6;

    // Reset with no clock edge, then held across an edge
    #1 rstn = 1'b0;
    #1 push_dark();
    check("reset_async");
    @(negedge clk);
    push_dark();
    check("reset_held");
    rstn = 1'b1;

    // Scan and snapshot boundaries, first frame dark
    for (int f = 0; f < 7; f++) begin
      run_cycles(frames[f].pats, frames[f].dark, 24, frames[f].chg_idx, frames[f].chg_val,
                 $sformatf("frame%0d", f));
    end

    // Enable dropped mid-slot; shadow follows inputs meanwhile
    run_cycles(T59, 1'b0, 6, -1, 7'h00, "en_pre");
    en    = 1'b0;
    sec_l = P5;
    for (int i = 0; i < 3; i++) begin
      push_dark();
      @(negedge clk);
      check($sformatf("en_off c%0d", i));
    end
    en = 1'b1;
    run_cycles(T55, 1'b0, 24, -1, 7'h00, "en_back");

    // Async reset in the middle of a lit cycle
    run_cycles(T55, 1'b0, 2, -1, 7'h00, "rst_pre");
    #2 rstn = 1'b0;
    #1 push_dark();
    check("rst_mid_async");
    @(negedge clk);
    push_dark();
    check("rst_mid_held");
    rstn = 1'b1;
    run_cycles(T55, 1'b1, 24, -1, 7'h00, "rst_dark");
    run_cycles(T55, 1'b0, 24, -1, 7'h00, "rst_lit");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
